// File: rtl/dm.sv
// DM: word-organised data memory with word/half/byte loads and stores, combinational read.
// Define DM_MISALIGN_TRAP_EN to add the misalign flag and suppress misaligned accesses.
module dm #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DMWr,
    input  logic        DMRd,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  DMType,
    output logic [31:0] dout,
    output logic [15:0] store_cnt
`ifdef DM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        DM_W  = 3'b000,
        DM_HS = 3'b001,
        DM_HU = 3'b010,
        DM_BS = 3'b011,
        DM_BU = 3'b100
    } dm_type_e;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [15:0]   half;
    logic [7:0]    bsel;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          rsvd;
    logic          mis;
    logic          commit;
    logic          unused_bits;

    assign idx         = addr[AW+1:2];
    assign word        = mem[idx];
    assign unused_bits = ^{DMRd, addr[31:AW+2]};

`ifdef DM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = (DMWr | DMRd) &
                   (((DMType == DM_W) & (addr[1:0] != 2'b00)) |
                    (((DMType == DM_HS) | (DMType == DM_HU)) & addr[0]));
        mis = misalign;
    end
`else
    always_comb mis = 1'b0;
`endif

    // Load extraction and store lane enables share the same type decode.
    always_comb begin
        half  = addr[1] ? word[31:16] : word[15:0];
        bsel  = word[{addr[1:0], 3'b000} +: 8];
        rsvd  = 1'b0;
        dout  = '0;
        be    = '0;
        wdata = din;
        case (DMType)
            DM_W: begin
                dout = word;
                be   = '1;
            end
            DM_HS, DM_HU: begin
                dout  = (DMType == DM_HS) ? {{16{half[15]}}, half} : {16'h0000, half};
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            DM_BS, DM_BU: begin
                dout  = (DMType == DM_BS) ? {{24{bsel[7]}}, bsel} : {24'h000000, bsel};
                be    = 4'b0001 << addr[1:0];
                wdata = {4{din[7:0]}};
            end
            default: rsvd = 1'b1;
        endcase
        if (mis) begin
            dout = '0;
        end
    end

    assign commit = DMWr & ~rst & ~rsvd & ~mis;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_cnt <= '0;
        end else if (commit && (store_cnt != '1)) begin
            store_cnt <= store_cnt + 16'd1;
        end
    end

endmodule

// File: doc/dm.md
DM -- requirements
Module: dm

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the data array (power of two, 4..65536).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port DMWr, input, 1, store enable for the current cycle.
REQ-005 SHALL have port DMRd, input, 1, load qualifier; used only for misalignment reporting.
REQ-006 SHALL have port addr, input, 32, byte address taken from the ALU result C.
REQ-007 SHALL have port din, input, 32, store data (rs2 value).
REQ-008 SHALL have port DMType, input, 3, access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 reserved.
REQ-009 SHALL have port dout, output, 32, load data with extension applied.
REQ-010 SHALL have port store_cnt, output, 16, count of committed stores.
REQ-011 SHALL have port misalign, output, 1, misaligned access flag; present only when DM_MISALIGN_TRAP_EN is defined.

Function
REQ-012 SHALL form the word index from addr[log2(DEPTH)+1:2]; higher address bits are ignored, so accesses wrap modulo DEPTH words.
REQ-013 SHALL select the byte lane with addr[1:0] and the half lane with addr[1].
REQ-014 SHALL read combinationally: dout reflects the array and the current inputs in the same cycle, with zero clock latency.
REQ-015 SHALL form dout as follows: word, the full word; half signed or unsigned, the selected 16 bits sign- or zero-extended; byte signed or unsigned, the selected 8 bits sign- or zero-extended; reserved DMType, 0.
REQ-016 SHALL commit a store on the rising edge when DMWr=1, rst=0 and the access is not suppressed.
REQ-017 SHALL write only the addressed lanes: word writes all 4 bytes; half writes din[15:0] into the selected half; byte writes din[7:0] into the selected byte; unselected bytes keep their value.
REQ-018 SHALL treat signed and unsigned types identically for stores.
REQ-019 SHALL suppress stores with a reserved DMType: no array change and no count increment.
REQ-020 SHALL, on a same-cycle store and load to the same word, present the old data on dout before the edge and the new data after it; there is no bypass.
REQ-021 SHALL increment store_cnt by 1 for each committed store, saturating at 16'hFFFF with no wrap.
REQ-022 SHALL never modify the array when DMWr=0, regardless of the other inputs.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, set store_cnt to 0 and suppress any store presented in that cycle.
REQ-024 SHALL leave array contents unaffected by reset; contents are undefined after power-up until written.
REQ-025 SHALL keep dout purely combinational and unaffected by rst.
REQ-026 SHALL resume normal operation on the first edge after rst deasserts, with no extra wait cycles.

Configuration
REQ-027 SHALL, with DM_MISALIGN_TRAP_EN defined, compute misalign = (DMWr|DMRd) & ((word & addr[1:0]!=0) | (half & addr[0]=1)), combinationally.
REQ-028 SHALL, with DM_MISALIGN_TRAP_EN defined, suppress any misaligned store (no array write, no count increment) and drive dout=0 for a misaligned load.
REQ-029 SHALL, without DM_MISALIGN_TRAP_EN, omit the misalign port, ignore addr[1:0] for word accesses and addr[0] for half accesses, and never suppress an access for alignment.

Verification
REQ-030 Bench SHALL cover: sw din=0x8000_00F1 to addr 0x10, then lb/lbu/lh/lhu/lw at 0x10 -> dout = 0xFFFF_FFF1 / 0x0000_00F1 / 0x0000_00F1 / 0x0000_00F1 / 0x8000_00F1.
REQ-031 Bench SHALL cover: sw 0x1122_3344 to 0x20, sb 0xAA to 0x22, sh 0xBEEF to 0x20 -> lw at 0x20 = 0x11AA_BEEF, and store_cnt = 3.
REQ-032 Bench SHALL cover: with DEPTH=1024, sw 0xCAFE_0001 to addr 0x0000_1004 -> lw at 0x4 = 0xCAFE_0001 (wrap).
REQ-033 Bench SHALL cover: sw 0x55 to 0x30 with rst=1 in the same cycle -> after reset, lw at 0x30 unchanged and store_cnt = 0.
REQ-034 Bench SHALL cover: 65540 consecutive sw -> store_cnt = 0xFFFF; reserved DMType=111 store -> no array change and no count change.
REQ-035 Bench SHALL cover, with DM_MISALIGN_TRAP_EN: sh to 0x41 -> misalign=1, word at 0x40 unchanged, store_cnt unchanged; lw at 0x42 -> misalign=1, dout=0.
